// File: rtl/bpu_update_ctrl.sv
// Branch predictor update controller: keeps fetch-side prediction records in
// an in-order queue, pairs them with execute-side resolutions, and produces
// one-cycle update pulses for the GHR, PHT, counter FIFO and BTB, plus a
// redirect pulse on mispredict followed by a short recovery window.
module bpu_update_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pred_valid,
    input  logic [XLEN-1:0]          i_pred_pc,
    input  logic                     i_pred_jump,
    input  logic [XLEN-1:0]          i_pred_target,
    output logic                     o_pred_ready,
    input  logic                     i_res_valid,
    input  logic                     i_res_is_branch,
    input  logic                     i_res_taken,
    input  logic [XLEN-1:0]          i_res_target,
    output logic                     o_res_ready,
    input  logic                     i_flush,
    output logic                     o_ghr_update,
    output logic                     o_last_jump,
    output logic                     o_upht_update,
    output logic                     o_satCnt_update,
    output logic                     o_ubtb_update,
    output logic [XLEN-1:0]          o_pc_jumpsrc,
    output logic [XLEN-1:0]          o_pc_jumpdst,
    output logic                     o_redirect,
    output logic [XLEN-1:0]          o_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      recCnt_q, recCnt_d;
    logic [AW:0]     wrPtr_q, wrPtr_d;
    logic [AW:0]     rdPtr_q, rdPtr_d;

    logic [XLEN-1:0] pcMem_q     [DEPTH];
    logic            jumpMem_q   [DEPTH];
    logic [XLEN-1:0] targetMem_q [DEPTH];

    logic            full;
    logic            empty;
    logic [XLEN-1:0] headPc;
    logic            headJump;
    logic [XLEN-1:0] headTarget;
    logic            predAccept;
    logic            resAccept;
    logic            mispredict;

    logic            ghrUpdate_q, lastJump_q, satCntUpdate_q, ubtbUpdate_q, redirect_q;
    logic [XLEN-1:0] jumpSrc_q, jumpDst_q, redirectPc_q;

    assign full       = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty      = (wrPtr_q == rdPtr_q);
    assign headPc     = pcMem_q[rdPtr_q[AW-1:0]];
    assign headJump   = jumpMem_q[rdPtr_q[AW-1:0]];
    assign headTarget = targetMem_q[rdPtr_q[AW-1:0]];

    assign o_pred_ready = (state_q == RUN) && !full;
    assign o_res_ready  = (state_q == RUN) && !empty;

    // A flush overrides everything in the same cycle, so neither handshake
    // is allowed to take effect while it is asserted.
    assign predAccept = i_pred_valid && o_pred_ready && !i_flush;
    assign resAccept  = i_res_valid && o_res_ready && !i_flush;
    assign mispredict = resAccept &&
                        ((i_res_taken != headJump) ||
                         (i_res_taken && (i_res_target != headTarget)));

    assign o_count = wrPtr_q - rdPtr_q;

    // Next-state logic: a mispredict opens a two-cycle recovery window.
    always_comb begin
        state_d  = state_q;
        recCnt_d = recCnt_q;
        if (i_flush) begin
            state_d  = RUN;
            recCnt_d = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mispredict) begin
                        state_d  = RECOVER;
                        recCnt_d = 2'd0;
                    end
                end
                RECOVER: begin
                    if (recCnt_q == 2'd1) begin
                        state_d  = RUN;
                        recCnt_d = 2'd0;
                    end else begin
                        recCnt_d = recCnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d  = RUN;
                    recCnt_d = 2'd0;
                end
            endcase
        end
    end

    // Pointer update: flush or mispredict drops every queued record, and any
    // enqueue offered in that cycle is discarded along with them.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (i_flush || mispredict) begin
            rdPtr_d = wrPtr_q;
        end else begin
            if (predAccept) wrPtr_d = wrPtr_q + 1'b1;
            if (resAccept)  rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // FSM and queue pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= RUN;
            recCnt_q <= 2'd0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
        end else begin
            state_q  <= state_d;
            recCnt_q <= recCnt_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
        end
    end

    // Record storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge i_clk) begin
        if (predAccept && !mispredict) begin
            pcMem_q[wrPtr_q[AW-1:0]]     <= i_pred_pc;
            jumpMem_q[wrPtr_q[AW-1:0]]   <= i_pred_jump;
            targetMem_q[wrPtr_q[AW-1:0]] <= i_pred_target;
        end
    end

    // Update and redirect pulses are registered one cycle after the accepted
    // resolution; the PC/target values hold until the next resolution.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ghrUpdate_q    <= 1'b0;
            lastJump_q     <= 1'b0;
            satCntUpdate_q <= 1'b0;
            ubtbUpdate_q   <= 1'b0;
            redirect_q     <= 1'b0;
            jumpSrc_q      <= '0;
            jumpDst_q      <= '0;
            redirectPc_q   <= '0;
        end else begin
            ghrUpdate_q    <= resAccept && i_res_is_branch;
            lastJump_q     <= resAccept && i_res_taken;
            satCntUpdate_q <= resAccept;
            ubtbUpdate_q   <= resAccept && i_res_taken &&
                              (!headJump || (headTarget != i_res_target));
            redirect_q     <= mispredict;
            if (resAccept) begin
                jumpSrc_q <= headPc;
                jumpDst_q <= i_res_target;
            end
            if (mispredict) begin
                redirectPc_q <= i_res_taken ? i_res_target : (headPc + XLEN'(4));
            end
        end
    end

    assign o_ghr_update    = ghrUpdate_q;
    assign o_upht_update   = ghrUpdate_q;
    assign o_last_jump     = lastJump_q;
    assign o_satCnt_update = satCntUpdate_q;
    assign o_ubtb_update   = ubtbUpdate_q;
    assign o_redirect      = redirect_q;
    assign o_pc_jumpsrc    = jumpSrc_q;
    assign o_pc_jumpdst    = jumpDst_q;
    assign o_redirect_pc   = redirectPc_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed testbench for bpu_update_ctrl with hand-computed expectations.
module tb_bpu_update_ctrl;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;

   logic            clock;
   logic            reset;
   logic            predValid;
   logic [XLEN-1:0] predPc;
   logic            predJump;
   logic [XLEN-1:0] predTarget;
   logic            predReady;
   logic            resValid;
   logic            resIsBranch;
   logic            resTaken;
   logic [XLEN-1:0] resTarget;
   logic            resReady;
   logic            flush;
   logic            ghrUpdate;
   logic            lastJump;
   logic            uphtUpdate;
   logic            satCntUpdate;
   logic            ubtbUpdate;
   logic [XLEN-1:0] pcJumpSrc;
   logic [XLEN-1:0] pcJumpDst;
   logic            redirect;
   logic [XLEN-1:0] redirectPc;
   logic [3:0]      count;

   int compared;
   int mismatched;

   bpu_update_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .i_clk           (clock),
      .i_rst           (reset),
      .i_pred_valid    (predValid),
      .i_pred_pc       (predPc),
      .i_pred_jump     (predJump),
      .i_pred_target   (predTarget),
      .o_pred_ready    (predReady),
      .i_res_valid     (resValid),
      .i_res_is_branch (resIsBranch),
      .i_res_taken     (resTaken),
      .i_res_target    (resTarget),
      .o_res_ready     (resReady),
      .i_flush         (flush),
      .o_ghr_update    (ghrUpdate),
      .o_last_jump     (lastJump),
      .o_upht_update   (uphtUpdate),
      .o_satCnt_update (satCntUpdate),
      .o_ubtb_update   (ubtbUpdate),
      .o_pc_jumpsrc    (pcJumpSrc),
      .o_pc_jumpdst    (pcJumpDst),
      .o_redirect      (redirect),
      .o_redirect_pc   (redirectPc),
      .o_count         (count)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land 1 ns after the rising edge
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   // Offer one prediction record for a single cycle
   task automatic enqueue(input logic [XLEN-1:0] pc, input logic jump, input logic [XLEN-1:0] target);
      predValid  = 1'b1;
      predPc     = pc;
      predJump   = jump;
      predTarget = target;
      applyStimulus();
      predValid  = 1'b0;
   endtask

   // Offer one resolution for a single cycle
   task automatic resolve(input logic isBranch, input logic taken, input logic [XLEN-1:0] target);
      resValid    = 1'b1;
      resIsBranch = isBranch;
      resTaken    = taken;
      resTarget   = target;
      applyStimulus();
      resValid    = 1'b0;
   endtask

   // Directed scenarios
   initial begin
      compared    = 0;
      mismatched  = 0;
      reset       = 1'b1;
      predValid   = 1'b0;
      predPc      = '0;
      predJump    = 1'b0;
      predTarget  = '0;
      resValid    = 1'b0;
      resIsBranch = 1'b0;
      resTaken    = 1'b0;
      resTarget   = '0;
      flush       = 1'b0;

      #12;
      checkOutput("rst_count", 64'(count), 64'd0);
      checkOutput("rst_redirect", 64'(redirect), 64'd0);
      checkOutput("rst_satcnt", 64'(satCntUpdate), 64'd0);
      checkOutput("rst_jumpsrc", 64'(pcJumpSrc), 64'd0);
      checkOutput("rst_redirpc", 64'(redirectPc), 64'd0);
      checkOutput("rst_resready", 64'(resReady), 64'd0);
      reset = 1'b0;
      applyStimulus();

      // Correct taken prediction
      enqueue(32'h100, 1'b1, 32'h200);
      checkOutput("t1_count1", 64'(count), 64'd1);
      checkOutput("t1_resready", 64'(resReady), 64'd1);
      resolve(1'b1, 1'b1, 32'h200);
      checkOutput("t1_ghr", 64'(ghrUpdate), 64'd1);
      checkOutput("t1_upht", 64'(uphtUpdate), 64'd1);
      checkOutput("t1_satcnt", 64'(satCntUpdate), 64'd1);
      checkOutput("t1_lastjump", 64'(lastJump), 64'd1);
      checkOutput("t1_ubtb", 64'(ubtbUpdate), 64'd0);
      checkOutput("t1_redirect", 64'(redirect), 64'd0);
      checkOutput("t1_count0", 64'(count), 64'd0);
      checkOutput("t1_jumpsrc", 64'(pcJumpSrc), 64'h100);
      checkOutput("t1_jumpdst", 64'(pcJumpDst), 64'h200);
      applyStimulus();
      checkOutput("t1_satcnt_drop", 64'(satCntUpdate), 64'd0);
      checkOutput("t1_jumpsrc_hold", 64'(pcJumpSrc), 64'h100);

      // Direction miss: predicted not taken, actually taken
      enqueue(32'h104, 1'b0, 32'h0);
      resolve(1'b1, 1'b1, 32'h300);
      checkOutput("t2_ubtb", 64'(ubtbUpdate), 64'd1);
      checkOutput("t2_jumpsrc", 64'(pcJumpSrc), 64'h104);
      checkOutput("t2_jumpdst", 64'(pcJumpDst), 64'h300);
      checkOutput("t2_redirect", 64'(redirect), 64'd1);
      checkOutput("t2_redirpc", 64'(redirectPc), 64'h300);
      checkOutput("t2_predready_r0", 64'(predReady), 64'd0);
      applyStimulus();
      checkOutput("t2_redirect_drop", 64'(redirect), 64'd0);
      checkOutput("t2_predready_r1", 64'(predReady), 64'd0);
      applyStimulus();
      checkOutput("t2_predready_back", 64'(predReady), 64'd1);

      // Not-taken miss on the first of three queued records
      enqueue(32'h10, 1'b1, 32'h50);
      enqueue(32'h14, 1'b0, 32'h0);
      enqueue(32'h18, 1'b0, 32'h0);
      checkOutput("t3_count3", 64'(count), 64'd3);
      resolve(1'b1, 1'b0, 32'h0);
      checkOutput("t3_redirect", 64'(redirect), 64'd1);
      checkOutput("t3_redirpc", 64'(redirectPc), 64'h14);
      checkOutput("t3_ubtb", 64'(ubtbUpdate), 64'd0);
      checkOutput("t3_lastjump", 64'(lastJump), 64'd0);
      applyStimulus();
      applyStimulus();
      checkOutput("t3_count_after", 64'(count), 64'd0);
      checkOutput("t3_predready", 64'(predReady), 64'd1);

      // Fill to capacity, then concurrent enqueue/dequeue at 7
      for (int i = 0; i < DEPTH; i++) begin
         enqueue(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      end
      checkOutput("t4_full_count", 64'(count), 64'd8);
      checkOutput("t4_full_ready", 64'(predReady), 64'd0);
      resolve(1'b1, 1'b0, 32'h0);
      checkOutput("t4_count7", 64'(count), 64'd7);
      checkOutput("t4_src0", 64'(pcJumpSrc), 64'h1000);
      predValid   = 1'b1;
      predPc      = 32'h2000;
      predJump    = 1'b0;
      predTarget  = 32'h0;
      resValid    = 1'b1;
      resIsBranch = 1'b1;
      resTaken    = 1'b0;
      resTarget   = 32'h0;
      applyStimulus();
      predValid   = 1'b0;
      resValid    = 1'b0;
      checkOutput("t4_count_same", 64'(count), 64'd7);
      checkOutput("t4_src1", 64'(pcJumpSrc), 64'h1004);
      for (int i = 2; i < DEPTH; i++) begin
         resolve(1'b1, 1'b0, 32'h0);
         checkOutput($sformatf("t4_drain%0d", i), 64'(pcJumpSrc), 64'h1000 + 64'(4 * i));
      end
      resolve(1'b1, 1'b0, 32'h0);
      checkOutput("t4_drain_new", 64'(pcJumpSrc), 64'h2000);
      checkOutput("t4_empty", 64'(count), 64'd0);

      // Twenty records in batches of five to walk the pointers around
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 5; j++) begin
            enqueue(32'h3000 + 32'(4 * (b * 5 + j)), 1'b1, 32'h4000 + 32'(b * 5 + j));
         end
         for (int j = 0; j < 5; j++) begin
            resolve(1'b1, 1'b1, 32'h4000 + 32'(b * 5 + j));
            checkOutput($sformatf("t5_src%0d", b * 5 + j), 64'(pcJumpSrc), 64'h3000 + 64'(4 * (b * 5 + j)));
            checkOutput($sformatf("t5_redir%0d", b * 5 + j), 64'(redirect), 64'd0);
         end
      end
      checkOutput("t5_empty", 64'(count), 64'd0);

      // Flush with a simultaneous mispredicting resolution
      for (int i = 0; i < 4; i++) begin
         enqueue(32'h500 + 32'(4 * i), 1'b1, 32'h600);
      end
      applyStimulus();
      flush       = 1'b1;
      resValid    = 1'b1;
      resIsBranch = 1'b1;
      resTaken    = 1'b0;
      resTarget   = 32'h0;
      predValid   = 1'b1;
      predPc      = 32'h700;
      applyStimulus();
      flush       = 1'b0;
      resValid    = 1'b0;
      predValid   = 1'b0;
      checkOutput("t6_count", 64'(count), 64'd0);
      checkOutput("t6_redirect", 64'(redirect), 64'd0);
      checkOutput("t6_satcnt", 64'(satCntUpdate), 64'd0);
      checkOutput("t6_ghr", 64'(ghrUpdate), 64'd0);
      checkOutput("t6_predready", 64'(predReady), 64'd1);

      // Asynchronous reset while a pulse is live
      enqueue(32'h800, 1'b1, 32'h900);
      enqueue(32'h804, 1'b1, 32'h900);
      resolve(1'b1, 1'b1, 32'h900);
      checkOutput("t7_pre_satcnt", 64'(satCntUpdate), 64'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("t7_satcnt", 64'(satCntUpdate), 64'd0);
      checkOutput("t7_ghr", 64'(ghrUpdate), 64'd0);
      checkOutput("t7_count", 64'(count), 64'd0);
      checkOutput("t7_jumpsrc", 64'(pcJumpSrc), 64'd0);
      checkOutput("t7_jumpdst", 64'(pcJumpDst), 64'd0);
      #1 reset = 1'b0;
      enqueue(32'hA00, 1'b0, 32'h0);
      checkOutput("t7_first_accept", 64'(count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
